// File: rtl/sdram_frame_writer_if.sv
// rtl/sdram_frame_writer_if.sv - pixel stream and SDRAM command bus bundle for the frame writer
interface sdram_frame_writer_if;
    logic        pixel_valid;
    logic [23:0] pixel_data;
    logic        pixel_last;
    logic        pixel_ready;
    logic        bus_request;
    logic        bus_grant;
    logic [1:0]  command;
    logic [21:0] data_address;
    logic [31:0] data_write;
    logic        data_write_done;

    // renderer / arbiter / controller side
    modport master (
        output pixel_valid, pixel_data, pixel_last, bus_grant, data_write_done,
        input  pixel_ready, bus_request, command, data_address, data_write
    );

    // frame writer side
    modport slave (
        input  pixel_valid, pixel_data, pixel_last, bus_grant, data_write_done,
        output pixel_ready, bus_request, command, data_address, data_write
    );
endinterface

// File: rtl/sdram_frame_writer.sv
// rtl/sdram_frame_writer.sv - buffered burst writer of a pixel stream into SDRAM (optional FRAME_WRITER_TAG_EN)
module sdram_frame_writer #(
    parameter int FRAME_PIXELS = 384000,
    parameter int BASE_ADDR    = 0,
    parameter int BURST_LENGTH = 8,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sdram_frame_writer_if.slave  bus,
    output logic                 frame_done,
    output logic                 frame_error
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int IW = $clog2(FRAME_PIXELS + 1);
    localparam int BW = $clog2(BURST_LENGTH + 1);

    localparam logic [1:0]    CMD_IDLE  = 2'd0;
    localparam logic [1:0]    CMD_WRITE = 2'd1;
    localparam logic [21:0]   BASE      = 22'(BASE_ADDR);
    localparam logic [IW-1:0] LAST_IDX  = IW'(FRAME_PIXELS - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] BURST_CNT = CW'(BURST_LENGTH);
    localparam logic [BW-1:0] BEAT_LOAD = BW'(BURST_LENGTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQUEST,
        S_WRITE,
        S_RELEASE
    } state_t;

    state_t state, state_next;

    // each entry is {last_flag, rgb}; last_flag also covers the implicit end of frame
    logic [24:0]   mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] last_count;
    logic [IW-1:0] in_idx;
    logic [BW-1:0] beat_cnt;
    logic [21:0]   wr_addr;
    logic [7:0]    tag;

    logic full;
    logic push;
    logic pop;
    logic in_last;
    logic head_last;
    logic empty_after_pop;

    assign full            = (count == FULL_CNT);
    assign bus.pixel_ready = rst_n && !full;
    assign push            = bus.pixel_valid && bus.pixel_ready;
    assign in_last         = bus.pixel_last || (in_idx == LAST_IDX);
    assign head_last       = mem[rd_ptr][24];
    assign pop             = (state == S_WRITE) && bus.data_write_done;
    assign empty_after_pop = (count == CW'(1)) && !push;

    assign bus.data_address = wr_addr;
    assign bus.data_write   = (state == S_WRITE) ? {tag, mem[rd_ptr][23:0]} : 32'd0;

    // FIFO storage; contents beyond the occupancy count are don't-care so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_last, bus.pixel_data};
        end
    end

    // FIFO pointers, occupancy, stored last-flag count, input pixel index and error flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            last_count  <= '0;
            in_idx      <= '0;
            frame_error <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                in_idx <= in_last ? '0 : in_idx + 1'b1;
                if (bus.pixel_last && (in_idx != LAST_IDX)) begin
                    frame_error <= 1'b1;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count      <= count + CW'(push) - CW'(pop);
            last_count <= last_count + CW'(push && in_last) - CW'(pop && head_last);
        end
    end

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next-state and bus control; a flushable last entry starts a short burst
    always_comb begin
        state_next      = state;
        bus.bus_request = 1'b0;
        bus.command     = CMD_IDLE;
        case (state)
            S_IDLE: begin
                if ((count >= BURST_CNT) || ((count != '0) && (last_count != '0))) begin
                    state_next = S_REQUEST;
                end
            end
            S_REQUEST: begin
                bus.bus_request = 1'b1;
                if (bus.bus_grant) begin
                    state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                bus.bus_request = 1'b1;
                bus.command     = CMD_WRITE;
                if (pop && ((beat_cnt == '0) || head_last || empty_after_pop)) begin
                    state_next = S_RELEASE;
                end
            end
            S_RELEASE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // beat counter, write address and end-of-frame pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            beat_cnt   <= '0;
            wr_addr    <= BASE;
            frame_done <= 1'b0;
        end else begin
            frame_done <= pop && head_last;
            if ((state == S_REQUEST) && bus.bus_grant) begin
                beat_cnt <= BEAT_LOAD;
            end else if (pop) begin
                beat_cnt <= beat_cnt - 1'b1;
            end
            if (pop) begin
                wr_addr <= head_last ? BASE : wr_addr + 22'd1;
            end
        end
    end

`ifdef FRAME_WRITER_TAG_EN
    logic [7:0] frame_count;

    // frame counter stamped into the upper byte of every written word
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_count <= 8'd0;
        end else if (frame_done) begin
            frame_count <= frame_count + 8'd1;
        end
    end

    assign tag = frame_count;
`else
    assign tag = 8'd0;
`endif

endmodule
